// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: pointer typedef, depth, Gray coding.
// Used by fifo_rd_ctrl (optional FIFO_RD_LEVEL_EN level output).
package fifo_pkg;

  localparam int PTR_LEN_DEF = 8;
  localparam int DEPTH = 2 ** PTR_LEN_DEF;
  localparam int FN_W = 32;

  typedef logic [PTR_LEN_DEF:0] ptr_t;

  // Zero-extended inputs keep these valid for any width up to FN_W
  function automatic logic [FN_W-1:0] bin2gray(
    input logic [FN_W-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [FN_W-1:0] gray2bin(
    input logic [FN_W-1:0] g
  );
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Async active-high reset clears every stage.
module ptr_sync #(
  parameter int W      = 9,
  parameter int STAGES = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [STAGES-1:0][W-1:0] sync_q;

  // Shift the pointer through the synchronizer chain
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-domain controller with first-word-fall-through stream.
// Define FIFO_RD_LEVEL_EN to add the registered rd_level output.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_LEN     = 8,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              rclk,
  input  logic              rd_srst,
  input  logic [PTR_LEN:0]  wptr_gray,
  output logic [PTR_LEN:0]  rptr_gray,
  output logic              ram_ren,
  output logic [PTR_LEN-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              empty
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [PTR_LEN:0]  rd_level
`endif
);

  localparam int PW = PTR_LEN + 1;

  logic [PW-1:0]     wptr_sync;
  logic [PW-1:0]     read_ptr_q, read_ptr_d;
  logic [PW-1:0]     rptr_gray_q;
  logic              h0v_q, h0v_d, h1v_q, h1v_d;
  logic [DATA_W-1:0] h0_q, h0_d, h1_q, h1_d;
  logic              rv_q, mv_q, mv_d;
  logic [1:0]        occ;
  logic              pop, ren, empty_w;

  ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_wsync (
    .clk_i (rclk),
    .rst_i (rd_srst),
    .d_i   (wptr_gray),
    .q_o   (wptr_sync)
  );

  // Empty when our Gray pointer matches the synced write pointer
  always_comb begin
    empty_w = (PW'(bin2gray(32'(read_ptr_q))) == wptr_sync);
  end

  // Issue a RAM read whenever a word exists and the buffer has room.
  // The word on ram_rdata (rv) counts as the in-flight entry.
  always_comb begin
    occ        = {1'b0, h0v_q} + {1'b0, h1v_q} + {1'b0, rv_q};
    pop        = mv_q & m_ready;
    ren        = !empty_w && ((occ - {1'b0, pop}) < 2'd2);
    read_ptr_d = ren ? read_ptr_q + PW'(1) : read_ptr_q;
  end

  // Holding registers: drop the head on pop, then capture any returned
  // word so ram_rdata is free to change on the next read.
  always_comb begin
    h0v_d = h0v_q;
    h1v_d = h1v_q;
    h0_d  = h0_q;
    h1_d  = h1_q;
    if (pop && h0v_q) begin
      h0v_d = h1v_q;
      h0_d  = h1_q;
      h1v_d = 1'b0;
    end
    if (rv_q && !(pop && !h0v_q)) begin
      if (!h0v_d) begin
        h0v_d = 1'b1;
        h0_d  = ram_rdata;
      end else begin
        h1v_d = 1'b1;
        h1_d  = ram_rdata;
      end
    end
    mv_d = h0v_d | ren;
  end

  // Pointer and buffer state
  always_ff @(posedge rclk or posedge rd_srst) begin
    if (rd_srst) begin
      read_ptr_q  <= '0;
      rptr_gray_q <= '0;
      h0v_q       <= 1'b0;
      h1v_q       <= 1'b0;
      h0_q        <= '0;
      h1_q        <= '0;
      rv_q        <= 1'b0;
      mv_q        <= 1'b0;
    end else begin
      read_ptr_q <= read_ptr_d;
      if (ren) begin
        rptr_gray_q <= PW'(bin2gray(32'(read_ptr_d)));
      end
      h0v_q <= h0v_d;
      h1v_q <= h1v_d;
      h0_q  <= h0_d;
      h1_q  <= h1_d;
      rv_q  <= ren;
      mv_q  <= mv_d;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] lvl_q;

  // Unread RAM words, excluding anything already in the buffer
  always_ff @(posedge rclk or posedge rd_srst) begin
    if (rd_srst) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= PW'(gray2bin(32'(wptr_sync))) - read_ptr_q;
    end
  end

  assign rd_level = lvl_q;
`endif

  assign empty     = empty_w;
  assign ram_ren   = ren;
  assign ram_raddr = read_ptr_q[PTR_LEN-1:0];
  assign rptr_gray = rptr_gray_q;
  assign m_valid   = mv_q;
  assign m_data    = (h0v_q || !rv_q) ? h0_q : ram_rdata;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: write-side model, RAM model and scoreboard.
// Define FIFO_RD_LEVEL_EN to also exercise rd_level.
module tb_fifo_rd_ctrl;

  localparam int PL = 2;
  localparam int DW = 8;
  localparam int PW = PL + 1;

  logic          rclk = 1'b0;
  logic          rd_srst = 1'b1;
  logic [PW-1:0] wptr_gray = '0;
  logic [PW-1:0] rptr_gray;
  logic          ram_ren;
  logic [PL-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          empty;
`ifdef FIFO_RD_LEVEL_EN
  logic [PW-1:0] rd_level;
`endif

  fifo_rd_ctrl #(
    .PTR_LEN     (PL),
    .DATA_W      (DW),
    .SYNC_STAGES (2)
  ) dut (
    .rclk      (rclk),
    .rd_srst   (rd_srst),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .empty     (empty)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level  (rd_level)
`endif
  );

  always #5 rclk = ~rclk;

  logic [DW-1:0] mem [4];

  always @(posedge rclk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
  end

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] exp_q [$];
  int            wcnt = 0;
  int            rcnt = 0;
  int            popcnt = 0;
  int            occ_m;
  logic          pop_m;
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d = '0;

  function automatic logic [PW-1:0] gray(input int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    mem[wcnt % 4] = d;
    exp_q.push_back(d);
    wcnt++;
    wptr_gray = gray(wcnt);
  endtask

  // Monitor: scoreboard pops, order, hold, occupancy and pointer checks
  always @(negedge rclk) begin
    if (rd_srst) begin
      rcnt   = 0;
      popcnt = 0;
      hold_v = 1'b0;
    end else begin
      occ_m = rcnt - popcnt;
      pop_m = m_valid && m_ready;
      chk("valid_vs_occ", 32'(m_valid), 32'(occ_m > 0));
      if (hold_v) begin
        chk("hold_valid", 32'(m_valid), 1);
        chk("hold_data", 32'(m_data), 32'(hold_d));
      end
      if (pop_m) begin
        chk("pop_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("data", 32'(m_data), 32'(exp_q.pop_front()));
        popcnt++;
      end
      chk("rptr_gray", 32'(rptr_gray), 32'(gray(rcnt)));
      if (ram_ren) begin
        chk("raddr", 32'(ram_raddr), 32'(rcnt % 4));
        chk("ren_has_data", 32'(wcnt - rcnt > 0), 1);
        chk("ren_room", 32'(occ_m - int'(pop_m) < 2), 1);
        rcnt++;
      end
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
    end
  end

  task automatic do_reset();
    @(posedge rclk);
    #3;
    rd_srst = 1'b1;
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_rptr", 32'(rptr_gray), 0);
    chk("rst_ren", 32'(ram_ren), 0);
`ifdef FIFO_RD_LEVEL_EN
    chk("rst_level", 32'(rd_level), 0);
`endif
    wptr_gray = '0;
    wcnt = 0;
    exp_q.delete();
    m_ready = 1'b0;
    repeat (2) @(posedge rclk);
    #3;
    rd_srst = 1'b0;
  endtask

  task automatic drain();
    m_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge rclk);
    @(posedge rclk);
    #1;
    chk("drain", 32'(exp_q.size()), 0);
    chk("drain_valid", 32'(m_valid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ren_n, ren_f, ren_l, pop_n, pop_f;

    repeat (2) @(posedge rclk);
    #1;
    chk("init_valid", 32'(m_valid), 0);
    chk("init_empty", 32'(empty), 1);
    chk("init_data", 32'(m_data), 0);
    chk("init_rptr", 32'(rptr_gray), 0);
    #2;
    rd_srst = 1'b0;

    // Single word latency
    @(posedge rclk);
    #1;
    write_word(8'hA0);
    @(posedge rclk);
    #1;
    chk("lat_empty1", 32'(empty), 1);
    @(posedge rclk);
    #1;
    chk("lat_empty0", 32'(empty), 0);
    chk("lat_ren", 32'(ram_ren), 1);
    chk("lat_raddr", 32'(ram_raddr), 0);
    @(posedge rclk);
    #1;
    chk("lat_valid", 32'(m_valid), 1);
    chk("lat_data", 32'(m_data), 32'h A0);
    chk("lat_rptr", 32'(rptr_gray), 1);
    chk("lat_empty", 32'(empty), 1);

    // Reset with a word buffered
    do_reset();

    // Four words, full throughput
    @(posedge rclk);
    #1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) write_word(DW'(8'hB0 + i));
    ren_n = 0; ren_f = -1; ren_l = -1; pop_n = 0; pop_f = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge rclk);
      if (ram_ren) begin
        if (ren_f < 0) ren_f = c;
        ren_l = c;
        ren_n++;
      end
      if (m_valid && m_ready) begin
        if (pop_f < 0) pop_f = c;
        pop_n++;
      end
    end
    chk("tp_ren_count", 32'(ren_n), 4);
    chk("tp_ren_span", 32'(ren_l - ren_f), 3);
    chk("tp_pop_count", 32'(pop_n), 4);
    chk("tp_pop_lat", 32'(pop_f - ren_f), 1);

    // Backpressure: only two reads outstanding
    do_reset();
    @(posedge rclk);
    #1;
    for (int i = 0; i < 4; i++) write_word(DW'(8'hC0 + i));
    ren_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge rclk);
      if (ram_ren) ren_n++;
    end
    chk("bp_ren_count", 32'(ren_n), 2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_data", 32'(m_data), 32'h C0);
    drain();

    // Stream ten words through the wrap
    do_reset();
    m_ready = 1'b1;
    for (int c = 0; c < 100 && wcnt < 10; c++) begin
      @(posedge rclk);
      #1;
      if (wcnt - rcnt < 4) write_word(DW'(8'hD0 + wcnt));
    end
    drain();
    chk("wrap_rptr", 32'(rptr_gray), 32'b011);

`ifdef FIFO_RD_LEVEL_EN
    do_reset();
    @(posedge rclk);
    #1;
    for (int i = 0; i < 3; i++) write_word(DW'(8'hE0 + i));
    repeat (8) @(posedge rclk);
    #1;
    chk("level", 32'(rd_level), 1);
`endif

    // Random traffic with a reset in the middle
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(posedge rclk);
      #1;
      m_ready = ($urandom % 4) != 0;
      if (($urandom % 2) == 1 && wcnt - rcnt < 4) write_word(DW'($urandom));
      if (c == 300) do_reset();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
